// File: rtl/clock_pkg.sv
// Shared constants for the time-of-day keeper: BCD field limits, Digit
// one-hot field selects and the BCD increment helper used by every field.
package clock_pkg;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  typedef enum logic [2:0] {
    SEL_NONE = 3'b000,
    SEL_SEC  = 3'b001,
    SEL_MIN  = 3'b010,
    SEL_HOUR = 3'b100
  } digit_sel_e;

  // Two-digit BCD +1 without range limiting; the caller applies the field wrap.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = v[7:4];
    units = v[3:0];
    if (units >= 4'd9) begin
      units = 4'd0;
      tens  = tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/bcd_field.sv
// One two-digit BCD time field counting 00..MAX; clr beats inc, and wrap
// flags the increment that takes the field from MAX back to 00.
module bcd_field
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = SEC_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       wrap
);

  assign wrap = inc && (value == MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? '0 : bcd_inc(value);
    end
  end

endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD time keeper with a second prescaler, in-place field editing
// and an edit-mode blink phase generator.
module time_keeper
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100000000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Editing,
  input  logic [2:0] Digit,
  input  logic       IncrementDigit,
  output logic [7:0] Hours,
  output logic [7:0] Minutes,
  output logic [7:0] Seconds,
  output logic       SecondTick,
  output logic       Rollover,
  output logic       Blink
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [BW-1:0] blink_cnt;
  logic          blink_q;
  logic          edit_q;

  logic edit_rise;
  logic tick;
  logic edit_inc;
  logic sec_inc, sec_clr, sec_wrap;
  logic min_inc, min_wrap;
  logic hour_inc, hour_wrap;

  // Editing has priority: a tick coinciding with edit entry is dropped.
  assign edit_rise = Editing && !edit_q;
  assign tick      = !Editing && (prescaler == TICK_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prescaler <= '0;
    end else if (Editing || tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (!Editing) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_q   <= !blink_q;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edit_q <= 1'b0;
    end else begin
      edit_q <= Editing;
    end
  end

  // Ticks and edit increments are mutually exclusive (Editing gates both),
  // so carries only ever come from the tick path.
  always_comb begin
    edit_inc = Editing && IncrementDigit && $onehot(Digit);
    sec_clr  = edit_rise;
    sec_inc  = tick || (edit_inc && (Digit == SEL_SEC) && !edit_rise);
    min_inc  = (tick && sec_wrap) || (edit_inc && (Digit == SEL_MIN));
    hour_inc = (tick && min_wrap) || (edit_inc && (Digit == SEL_HOUR));
  end

  bcd_field #(.MAX(SEC_MAX)) u_sec (
    .clk   (CLK),
    .rst   (RST),
    .inc   (sec_inc),
    .clr   (sec_clr),
    .value (Seconds),
    .wrap  (sec_wrap)
  );

  bcd_field #(.MAX(MIN_MAX)) u_min (
    .clk   (CLK),
    .rst   (RST),
    .inc   (min_inc),
    .clr   (1'b0),
    .value (Minutes),
    .wrap  (min_wrap)
  );

  bcd_field #(.MAX(HOUR_MAX)) u_hour (
    .clk   (CLK),
    .rst   (RST),
    .inc   (hour_inc),
    .clr   (1'b0),
    .value (Hours),
    .wrap  (hour_wrap)
  );

  assign SecondTick = tick;
  assign Rollover   = tick && hour_wrap;
  assign Blink      = blink_q && Editing;

endmodule
